lmc_ram_sequencer: RTL
======================

Name: lmc_ram_sequencer

Overview:
- Controller for the LMC 2^N x M program RAM and its address counter.
- Shares the single RAM port between two users:
  - manual programming: the Counter_load and RAM_button push-buttons plus the data_in switches;
  - a run-mode fetch sequencer that steps through memory and presents each word to the downstream decoder.
- Drives address, write-enable and write-data to an external RAM with asynchronous read.

Parameters:
- N, 2, address width; RAM depth is 2^N words.
- M, 4, data word width.
- HALT_OP, 0, M-bit word value that stops run mode when fetched.

Ports:
- timer555  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Counter_load  input  1  button level; a rising edge loads the address counter from data_in[N-1:0].
- RAM_button  input  1  button level; a rising edge writes data_in to RAM at the current address.
- data_in  input  M  switch data: address source for a load, data source for a write.
- run  input  1  level; a rising edge in IDLE starts run mode; low aborts run mode.
- ram_rdata  input  M  RAM read data, valid in the same cycle as ram_addr (asynchronous read).
- ram_addr  output  N  registered address counter driven to the RAM.
- ram_we  output  1  RAM write strobe, exactly one cycle per accepted write.
- ram_wdata  output  M  registered write data.
- instr  output  M  last fetched word.
- instr_valid  output  1  one-cycle pulse when instr is updated.
- busy  output  1  high in FETCH and NEXT.
- halted  output  1  high in HALT.

Behaviour:
- Reset (synchronous, active-high):
  - ram_addr=0, ram_we=0, ram_wdata=0, instr=0, instr_valid=0, busy=0, halted=0, state=IDLE.
  - Edge-detect registers for Counter_load, RAM_button and run are cleared to 0, so a button held through reset counts as one press on the first cycle after reset.
  - Reset mid-write or mid-run aborts immediately; no pending write survives.
- Edge detection: rise = in & ~in_q, with in_q registered every cycle in every state.
- States: IDLE, WRITE, FETCH, NEXT, HALT.
- IDLE, priority order evaluated each cycle:
  1. run rise: ram_addr<=0, go FETCH.
  2. Counter_load rise: ram_addr<=data_in[N-1:0], stay IDLE.
  3. RAM_button rise: ram_wdata<=data_in, go WRITE.
  - A simultaneous lower-priority edge is discarded, not queued.
- WRITE (1 cycle): ram_we=1, ram_addr unchanged, then return to IDLE. Button edges arriving during WRITE are discarded.
- FETCH (1 cycle):
  - ram_addr drives the RAM.
  - If run=1: instr<=ram_rdata, instr_valid<=1, go NEXT.
  - If run=0: go IDLE, no capture, ram_addr held.
- NEXT (1 cycle, instr_valid=1 from the registered pulse):
  - run=0: go IDLE, ram_addr held.
  - else if instr==HALT_OP: go HALT, ram_addr held at the halting word.
  - else if ram_addr==2^N-1: go HALT, ram_addr held (end of memory; no wrap in run mode).
  - else: ram_addr<=ram_addr+1, go FETCH.
- Throughput: one word every 2 cycles; first instr_valid occurs 2 cycles after the run-rise edge is sampled.
- HALT: halted=1, busy=0. Leave to IDLE when run=0. Button edges are ignored.
- Button edges in FETCH, NEXT and HALT are discarded.
- busy=1 exactly in FETCH and NEXT.
- ram_we is 0 outside WRITE.
- Address arithmetic is modulo 2^N.

Optional Feature:
- Macro: LMC_AUTO_INC_EN.
- Defined: on leaving WRITE, ram_addr<=ram_addr+1 with wrap (2^N-1 -> 0). Consecutive RAM_button presses then fill sequential words without reloading the counter.
- Undefined: ram_addr is unchanged by writes; each word needs its own Counter_load.

Test Plan:
- Reset while RAM_button held, then released -> ram_we pulses once in cycle 2 after reset at ram_addr=0; all outputs 0 during reset.
- Program via buttons (N=2, M=4, macro off): load 0/write 1, load 1/write 2, load 2/write 4, load 3/write 8 -> ram_we pulses at addr 0,1,2,3 with ram_wdata 1,2,4,8; ram_addr stays at 3.
- Counter_load and RAM_button rise in the same cycle with data_in=4'b0110 -> ram_addr=2, no ram_we pulse.
- Run with RAM={1,2,4,8} -> instr_valid every 2nd cycle with instr 1,2,4,8; then halted=1 and ram_addr=3; run low -> IDLE.
- Run with RAM={3,0,5,7}, HALT_OP=0 -> instr 3 then 0; halted=1 with ram_addr=1; 5 never fetched.
- Run drops during the second FETCH -> no second instr_valid, IDLE next cycle, ram_addr=1. With LMC_AUTO_INC_EN: write at addr 3 -> ram_addr wraps to 0.

Source files
------------

// File: rtl/lmc_ram_sequencer_if.sv
// lmc_ram_sequencer_if: button/switch inputs, RAM port and fetch outputs of the LMC RAM sequencer.
interface lmc_ram_sequencer_if #(
  parameter int N = 2,
  parameter int M = 4
);
  logic         Counter_load;
  logic         RAM_button;
  logic [M-1:0] data_in;
  logic         run;
  logic [M-1:0] ram_rdata;
  logic [N-1:0] ram_addr;
  logic         ram_we;
  logic [M-1:0] ram_wdata;
  logic [M-1:0] instr;
  logic         instr_valid;
  logic         busy;
  logic         halted;
  modport master (
    output Counter_load, RAM_button, data_in, run, ram_rdata,
    input  ram_addr, ram_we, ram_wdata, instr, instr_valid, busy, halted
  );
  modport slave (
    input  Counter_load, RAM_button, data_in, run, ram_rdata,
    output ram_addr, ram_we, ram_wdata, instr, instr_valid, busy, halted
  );
endinterface

// File: rtl/lmc_ram_sequencer.sv
// lmc_ram_sequencer: shares one async-read RAM port between button programming and a run-mode fetch loop.
// Optional LMC_AUTO_INC_EN: post-increment (with wrap) the address counter after every write.
module lmc_ram_sequencer #(
  parameter int          N       = 2,
  parameter int          M       = 4,
  parameter logic [M-1:0] HALT_OP = '0
) (
  input logic timer555,
  input logic reset,
  lmc_ram_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, FETCH, NEXT, HALT} state_t;
  state_t       r_state;
  logic         r_ld_q, r_btn_q, r_run_q;
  logic [N-1:0] r_addr;
  logic [M-1:0] r_wdata, r_instr;
  logic         r_we, r_valid, r_busy, r_halted;
  logic         w_ld_rise, w_btn_rise, w_run_rise;
  assign w_ld_rise  = bus.Counter_load & ~r_ld_q;
  assign w_btn_rise = bus.RAM_button & ~r_btn_q;
  assign w_run_rise = bus.run & ~r_run_q;
  always_ff @(posedge timer555) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ld_q   <= 1'b0;
      r_btn_q  <= 1'b0;
      r_run_q  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_instr  <= '0;
      r_we     <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_ld_q  <= bus.Counter_load;
      r_btn_q <= bus.RAM_button;
      r_run_q <= bus.run;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_run_rise) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end else if (w_ld_rise) begin
            r_addr <= bus.data_in[N-1:0];
          end else if (w_btn_rise) begin
            r_wdata <= bus.data_in;
            r_we    <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
`ifdef LMC_AUTO_INC_EN
          r_addr <= r_addr + 1'b1;
`endif
          r_state <= IDLE;
        end
        FETCH: begin
          if (bus.run) begin
            r_instr <= bus.ram_rdata;
            r_valid <= 1'b1;
            r_state <= NEXT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        NEXT: begin
          if (!bus.run) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_instr == HALT_OP || r_addr == '1) begin
            // stop on the halting word or at the last address; run mode never wraps
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= FETCH;
          end
        end
        HALT: begin
          if (!bus.run) begin
            r_halted <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ram_addr    = r_addr;
  assign bus.ram_we      = r_we;
  assign bus.ram_wdata   = r_wdata;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
endmodule
